rf_multiport: RTL and testbench

RF_MULTIPORT -- requirements
Module: rf_multiport

---
 rtl/pipeline_pkg.sv | 9 +
 rtl/rf_scoreboard.sv | 33 +++
 rtl/rf_multiport.sv | 58 +++++
 tb/tb_rf_multiport.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// pipeline: shared datapath width and writeback bundle for the pipeline stages
package pipeline;
  localparam int XLEN = 32;
  typedef logic [5:0] reg_addr_t;
  typedef struct packed {
    reg_addr_t rd_addr;
    logic [XLEN-1:0] data;
  } writeback_signals;
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: one busy bit per register, set on issue, cleared on writeback or flush
module rf_scoreboard #(
  parameter int NREGS = 32,
  parameter int NRD = 2,
  parameter int NWR = 1,
  localparam int AW = $clog2(NREGS)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic issue_valid,
  input  logic [AW-1:0] issue_rd,
  input  logic [NWR-1:0] wb_en,
  input  logic [NWR-1:0][AW-1:0] wb_addr,
  input  logic flush,
  input  logic [NRD-1:0][AW-1:0] rd_addr,
  output logic [NRD-1:0] rd_busy
);
  logic [NREGS-1:0] busy, busy_nxt;
  // a new producer outranks a retiring one; flush outranks both
  always_comb begin
    busy_nxt = busy;
    for (int i = 0; i < NWR; i++)
      if (wb_en[i]) busy_nxt[wb_addr[i]] = 1'b0;
    if (issue_valid) busy_nxt[issue_rd] = 1'b1;
    if (flush) busy_nxt = '0;
    busy_nxt[0] = 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) busy <= '0;
    else busy <= busy_nxt;
  always_comb
    for (int k = 0; k < NRD; k++) rd_busy[k] = busy[rd_addr[k]];
endmodule

// File: rtl/rf_multiport.sv
// rf_multiport: multi-port register file with pending-write scoreboard
// Define RF_BYPASS_EN to forward same-cycle writeback data to the read ports.
module rf_multiport
  import pipeline::*;
#(
  parameter int NREGS = 32,
  parameter int NRD = 2,
  parameter int NWR = 1,
  localparam int AW = $clog2(NREGS)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [NRD-1:0][AW-1:0] rd_addr,
  output logic [NRD-1:0][XLEN-1:0] rd_data,
  output logic [NRD-1:0] rd_busy,
  input  writeback_signals [NWR-1:0] wb,
  input  logic issue_valid,
  input  logic [AW-1:0] issue_rd,
  input  logic flush
);
  logic [XLEN-1:0] regs [NREGS];
  logic [NWR-1:0] wb_en;
  logic [NWR-1:0][AW-1:0] wb_addr;
  logic [NRD-1:0] sb_busy, hit;
  always_comb
    for (int i = 0; i < NWR; i++) begin
      wb_en[i] = wb[i].rd_addr != '0;
      wb_addr[i] = wb[i].rd_addr[AW-1:0];
    end
  // later ports overwrite earlier ones, so the highest index wins
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    else for (int i = 0; i < NWR; i++) if (wb_en[i]) regs[wb_addr[i]] <= wb[i].data;
  always_comb
    for (int k = 0; k < NRD; k++) begin
      rd_data[k] = rd_addr[k] == '0 ? '0 : regs[rd_addr[k]];
      hit[k] = 1'b0;
`ifdef RF_BYPASS_EN
      for (int i = 0; i < NWR; i++)
        if (wb_en[i] && wb_addr[i] == rd_addr[k]) begin
          rd_data[k] = wb[i].data;
          hit[k] = 1'b1;
        end
`endif
    end
  assign rd_busy = sb_busy & ~hit;
  rf_scoreboard #(.NREGS(NREGS), .NRD(NRD), .NWR(NWR)) u_sb (
    .clk(clk),
    .rst_n(rst_n),
    .issue_valid(issue_valid),
    .issue_rd(issue_rd),
    .wb_en(wb_en),
    .wb_addr(wb_addr),
    .flush(flush),
    .rd_addr(rd_addr),
    .rd_busy(sb_busy)
  );
endmodule

// File: tb/tb_rf_multiport.sv
// tb_rf_multiport: directed checks of the register file and scoreboard
module tb_rf_multiport;
  import pipeline::*;
  logic clk = 1'b0;
  logic rst_n;
  logic [1:0][4:0] rd_addr;
  logic [1:0][31:0] rd_data;
  logic [1:0] rd_busy;
  writeback_signals [1:0] wb;
  logic issue_valid;
  logic [4:0] issue_rd;
  logic flush;
  int checks = 0;
  int errors = 0;
`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  rf_multiport #(.NREGS(32), .NRD(2), .NWR(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .rd_busy(rd_busy),
    .wb(wb),
    .issue_valid(issue_valid),
    .issue_rd(issue_rd),
    .flush(flush)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    wb = '0;
    issue_valid = 1'b0;
    issue_rd = '0;
    flush = 1'b0;
  endtask
  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr[0] = a0;
    rd_addr[1] = a1;
    #1;
  endtask
  initial begin
    rst_n = 1'b0;
    idle();
    rd_addr = '0;
    #2;
    for (int i = 0; i < 32; i++) begin
      rd(5'(i), 5'(31 - i));
      check("rst_data0", rd_data[0], 32'h0);
      check("rst_data1", rd_data[1], 32'h0);
      check("rst_busy", {30'b0, rd_busy}, 32'h0);
    end
    step();
    rst_n = 1'b1;
    step();
    wb[0] = '{rd_addr: 6'd5, data: 32'hDEADBEEF};
    rd(5'd5, 5'd0);
    check("wb5_same", rd_data[0], BYP ? 32'hDEADBEEF : 32'h0);
    check("wb5_busy", {31'b0, rd_busy[0]}, 32'h0);
    step();
    idle();
    rd(5'd5, 5'd0);
    check("wb5_next", rd_data[0], 32'hDEADBEEF);
    wb[0] = '{rd_addr: 6'd7, data: 32'h11};
    wb[1] = '{rd_addr: 6'd7, data: 32'h22};
    rd(5'd7, 5'd7);
    check("dual7_same", rd_data[1], BYP ? 32'h22 : 32'h0);
    step();
    idle();
    rd(5'd7, 5'd5);
    check("dual7_next", rd_data[0], 32'h22);
    check("keep5", rd_data[1], 32'hDEADBEEF);
    issue_valid = 1'b1;
    issue_rd = 5'd9;
    step();
    idle();
    rd(5'd0, 5'd9);
    check("busy9_set", {31'b0, rd_busy[1]}, 32'h1);
    issue_valid = 1'b1;
    issue_rd = 5'd9;
    wb[0] = '{rd_addr: 6'd9, data: 32'h99};
    rd(5'd0, 5'd9);
    check("busy9_same", {31'b0, rd_busy[1]}, BYP ? 32'h0 : 32'h1);
    step();
    idle();
    rd(5'd0, 5'd9);
    check("busy9_keep", {31'b0, rd_busy[1]}, 32'h1);
    check("data9", rd_data[1], 32'h99);
    wb[0] = '{rd_addr: 6'd9, data: 32'hAA};
    step();
    idle();
    rd(5'd9, 5'd9);
    check("busy9_clr", {31'b0, rd_busy[1]}, 32'h0);
    check("data9_aa", rd_data[0], 32'hAA);
    wb[1] = '{rd_addr: 6'd0, data: 32'hFFFFFFFF};
    issue_valid = 1'b1;
    issue_rd = 5'd0;
    rd(5'd0, 5'd0);
    check("r0_same", rd_data[0], 32'h0);
    check("r0_busy_same", {31'b0, rd_busy[0]}, 32'h0);
    step();
    idle();
    rd(5'd0, 5'd0);
    check("r0_next", rd_data[0], 32'h0);
    check("r0_busy_next", {31'b0, rd_busy[0]}, 32'h0);
    issue_valid = 1'b1;
    issue_rd = 5'd3;
    step();
    issue_rd = 5'd4;
    step();
    idle();
    rd(5'd3, 5'd4);
    check("busy34", {30'b0, rd_busy}, 32'h3);
    flush = 1'b1;
    issue_valid = 1'b1;
    issue_rd = 5'd6;
    wb[1] = '{rd_addr: 6'd12, data: 32'h1234};
    step();
    idle();
    rd(5'd3, 5'd4);
    check("flush34", {30'b0, rd_busy}, 32'h0);
    rd(5'd6, 5'd12);
    check("flush6", {31'b0, rd_busy[0]}, 32'h0);
    check("flush_wb12", rd_data[1], 32'h1234);
    rd(5'd5, 5'd7);
    check("flush_keep5", rd_data[0], 32'hDEADBEEF);
    check("flush_keep7", rd_data[1], 32'h22);
    issue_valid = 1'b1;
    issue_rd = 5'd3;
    wb[0] = '{rd_addr: 6'd20, data: 32'h55};
    step();
    idle();
    rd(5'd20, 5'd3);
    check("pre_rst20", rd_data[0], 32'h55);
    check("pre_rst_busy3", {31'b0, rd_busy[1]}, 32'h1);
    rst_n = 1'b0;
    rd(5'd20, 5'd3);
    check("async_rst20", rd_data[0], 32'h0);
    check("async_rst_busy3", {31'b0, rd_busy[1]}, 32'h0);
    rd(5'd5, 5'd7);
    check("async_rst5", rd_data[0], 32'h0);
    check("async_rst7", rd_data[1], 32'h0);
    rst_n = 1'b1;
    issue_valid = 1'b1;
    issue_rd = 5'd3;
    wb[0] = '{rd_addr: 6'd20, data: 32'h66};
    step();
    idle();
    rd(5'd20, 5'd3);
    check("post_rst20", rd_data[0], 32'h66);
    check("post_rst_busy3", {31'b0, rd_busy[1]}, 32'h1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
